// File: rtl/bitwise_pkg.sv
// Shared op-code type and per-bit evaluator for the pipelined bitwise logic unit.
package bitwise_pkg;

   typedef enum logic [2:0] {
      OP_NOT  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_XOR  = 3'd3,
      OP_NAND = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_t;

   // Single-bit evaluation; the ops are carry-free so the top applies this per bit lane.
   function automatic logic bitwise_eval(input op_t op, input logic a, input logic b);
      logic r;
      case (op)
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_PASS: r = a;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bitwise_stage.sv
// One pipeline slot: a valid flag plus data, loaded when the downstream side frees the slot.
module bitwise_stage #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d,
   output logic             q_valid,
   output logic [WIDTH-1:0] q
);

   // Data only moves on a real beat, so y holds its last value through bubbles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_valid <= 1'b0;
         q       <= '0;
      end else if (load) begin
         q_valid <= d_valid;
         if (d_valid) begin
            q <= d;
         end
      end
   end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshake and a delivered-result counter.
// Optional reduction outputs (red_and/red_or/red_xor) are enabled by defining BITWISE_REDUCE_EN.
module bitwise_logic_pipe
   import bitwise_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [CNT_W-1:0] count
`ifdef BITWISE_REDUCE_EN
   ,
   output logic             red_and,
   output logic             red_or,
   output logic             red_xor
`endif
);

`ifdef BITWISE_REDUCE_EN
   localparam int DW = WIDTH + 3;
`else
   localparam int DW = WIDTH;
`endif

   logic [WIDTH-1:0]  res;
   logic [DW-1:0]     head;
   logic [STAGES-1:0] v;
   logic [STAGES-1:0] load;
   logic [DW-1:0]     d [STAGES];

   // Op logic ahead of stage 1; reductions ride in the top bits of the stage word.
   always_comb begin
      res = '0;
      for (int i = 0; i < WIDTH; i++) begin
         res[i] = bitwise_eval(op_t'(op), a[i], b[i]);
      end
`ifdef BITWISE_REDUCE_EN
      head = {&res, |res, ^res, res};
`else
      head = res;
`endif
   end

   // A slot may load if it, or any slot after it, is empty, or the consumer is taking;
   // this is the unrolled form of the no-bubble ready chain.
   always_comb begin
      logic acc;
      load = '0;
      acc  = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc     = acc | ~v[k];
         load[k] = acc;
      end
   end

   assign in_ready = load[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          vin;
      logic [DW-1:0] din;
      if (k == 0) begin : g_first
         assign vin = in_valid;
         assign din = head;
      end else begin : g_next
         assign vin = v[k-1];
         assign din = d[k-1];
      end
      bitwise_stage #(.WIDTH(DW)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .load    (load[k]),
         .d_valid (vin),
         .d       (din),
         .q_valid (v[k]),
         .q       (d[k])
      );
   end

   assign out_valid = v[STAGES-1];
   assign y         = d[STAGES-1][WIDTH-1:0];
`ifdef BITWISE_REDUCE_EN
   assign red_and   = d[STAGES-1][WIDTH+2];
   assign red_or    = d[STAGES-1][WIDTH+1];
   assign red_xor   = d[STAGES-1][WIDTH];
`endif

   // Delivered-result counter, wraps modulo 2^CNT_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (out_valid && out_ready) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe (STAGES=3, CNT_W=4); reduction checks when BITWISE_REDUCE_EN is defined.
module tb_bitwise_logic_pipe;
   localparam int WIDTH  = 4;
   localparam int STAGES = 3;
   localparam int CNT_W  = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2:0]       op = 3'd0;
   logic [WIDTH-1:0] a = 4'd0;
   logic [WIDTH-1:0] b = 4'd0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] y;
   logic [CNT_W-1:0] count;
`ifdef BITWISE_REDUCE_EN
   logic red_and, red_or, red_xor;
`endif

   bitwise_logic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .count     (count)
`ifdef BITWISE_REDUCE_EN
      ,
      .red_and   (red_and),
      .red_or    (red_or),
      .red_xor   (red_xor)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] y;
      logic [2:0] red;
      int         acc_cyc;
      bit         chk_lat;
   } exp_t;

   exp_t       sb[$];
   int         del_cyc[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         model_cnt = 0;
   bit         stalled = 1'b0;
   logic [3:0] held_y = 4'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] red_of(input logic [3:0] v);
      return {&v, |v, ^v};
   endfunction

   // Monitor: checks stall stability and pops the scoreboard on every delivery.
   always @(negedge clk) begin
      if (reset) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_y", 32'(y), 32'(held_y));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_out: got y=%0h expected no output", y);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("y", 32'(y), 32'(e.y));
`ifdef BITWISE_REDUCE_EN
               check("red", 32'({red_and, red_or, red_xor}), 32'(e.red));
`endif
               if (e.chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
               model_cnt = (model_cnt + 1) % 16;
               del_cyc.push_back(cyc);
            end
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled = 1'b1;
            held_y  = y;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic offer(input logic [2:0] o, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] ey, input logic [2:0] er, input bit lat,
                        input logic rdy, output bit acc);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid  = 1'b1;
      op        = o;
      a         = av;
      b         = bv;
      out_ready = rdy;
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
         e.y = ey; e.red = er; e.acc_cyc = cyc; e.chk_lat = lat;
         sb.push_back(e);
      end
   endtask

   task automatic send(input logic [2:0] o, input logic [3:0] av, input logic [3:0] bv,
                       input logic [3:0] ey, input bit lat);
      bit acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 30) begin
         offer(o, av, bv, ey, red_of(ey), lat, 1'b1, acc);
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready=0 expected acceptance within 30 cycles");
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || out_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain_left", 32'(sb.size()), 32'd0);
   endtask

   logic [3:0] t2_exp [8];
   bit         acc;
   int         nacc;

   initial begin
      t2_exp = '{4'b0011, 4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100};

      #1 reset = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // T1: NOT sweep; 16 deliveries wrap the 4-bit counter to 0.
      for (int i = 0; i < 16; i++) send(3'd0, 4'(i), 4'd0, 4'b1111 ^ 4'(i), 1'b1);
      idle();
      drain();
      check("t1_count", 32'(count), 32'd0);

      // T2: every op on a=1100, b=1010.
      for (int i = 0; i < 8; i++) send(3'(i), 4'b1100, 4'b1010, t2_exp[i], 1'b1);
      idle();
      drain();
      check("t2_count", 32'(count), 32'd8);

      // T3: backpressure fills the pipe, then four results in consecutive cycles.
      del_cyc.delete();
      nacc = 0;
      for (int i = 1; i <= 4; i++) begin
         offer(3'd7, 4'(i), 4'd0, 4'(i), red_of(4'(i)), 1'b0, 1'b0, acc);
         if (acc) nacc++;
      end
      check("t3_accepted", 32'(nacc), 32'd3);
      check("t3_full_in_ready", 32'(in_ready), 32'd0);
      offer(3'd7, 4'd4, 4'd0, 4'd4, red_of(4'd4), 1'b0, 1'b1, acc);
      check("t3_take_and_accept", 32'(acc), 32'd1);
      idle();
      drain();
      check("t3_deliveries", 32'(del_cyc.size()), 32'd4);
      if (del_cyc.size() == 4) check("t3_no_gap", 32'(del_cyc[3] - del_cyc[0]), 32'd3);
      check("t3_count", 32'(count), 32'd12);

      // T4: counter wrap 15 -> 0 -> 1.
      send(3'd3, 4'b0011, 4'b0101, 4'b0110, 1'b1);
      send(3'd3, 4'b1111, 4'b0000, 4'b1111, 1'b1);
      send(3'd3, 4'b1010, 4'b1010, 4'b0000, 1'b1);
      idle();
      drain();
      check("t4_count15", 32'(count), 32'd15);
      send(3'd1, 4'b1111, 4'b1001, 4'b1001, 1'b1);
      idle();
      drain();
      check("t4_count0", 32'(count), 32'd0);
      send(3'd2, 4'b0001, 4'b0010, 4'b0011, 1'b1);
      idle();
      drain();
      check("t4_count1", 32'(count), 32'd1);
      check("t4_model_count", 32'(count), 32'(model_cnt));

      // T5: reset with two beats in flight.
      offer(3'd1, 4'b1111, 4'b0101, 4'b0101, 3'b010, 1'b0, 1'b0, acc);
      check("t5_acc1", 32'(acc), 32'd1);
      offer(3'd2, 4'b0001, 4'b1000, 4'b1001, 3'b010, 1'b0, 1'b0, acc);
      check("t5_acc2", 32'(acc), 32'd1);
      @(posedge clk);
      #3;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      check("t5_out_valid", 32'(out_valid), 32'd0);
      check("t5_y", 32'(y), 32'd0);
      check("t5_count", 32'(count), 32'd0);
      sb.delete();
      model_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("t5_in_ready", 32'(in_ready), 32'd1);
      send(3'd0, 4'b0110, 4'd0, 4'b1001, 1'b1);
      idle();
      drain();
      check("t5_count_after", 32'(count), 32'd1);

      // T6: reduction vectors with hand-computed {and,or,xor}.
      begin
         exp_t e;
         for (int i = 0; i < 3; i++) begin
            logic [3:0] v6;
            logic [2:0] r6;
            v6 = (i == 0) ? 4'b0000 : (i == 1) ? 4'b1111 : 4'b0110;
            r6 = (i == 0) ? 3'b000  : (i == 1) ? 3'b110  : 3'b010;
            acc = 1'b0;
            for (int n = 0; n < 30 && !acc; n++) offer(3'd7, v6, 4'd0, v6, r6, 1'b1, 1'b1, acc);
            check("t6_accept", 32'(acc), 32'd1);
         end
         e.y = 4'd0;
      end
      idle();
      drain();
      check("t6_count", 32'(count), 32'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
